req_arbiter: RTL and testbench
==============================

// Module: req_arbiter
// PURPOSE
//   Shares one downstream resource among NUM_REQ requesters. Picks one owner per
//   arbitration using the team's priority-encoder rule (highest index wins) or
//   round-robin, holds the grant until release, and enforces a hold-time limit.
//   Sits between the request sources and the shared datapath/bus mux select.
// PARAMETERS
//   NUM_REQ   4   number of requesters; legal 2..8; ID_W = $clog2(NUM_REQ)
//   MAX_HOLD  16  max cycles one grant may last; 0 = no limit
// PORTS
//   clk        in   1        single clock; all state updates on posedge
//   rst        in   1        synchronous, active-high reset
//   req        in   NUM_REQ  level request per requester; held until served
//   done       in   1        owner releases the resource this cycle
//   rr_mode    in   1        0 = fixed priority (highest index), 1 = round-robin
//   gnt        out  NUM_REQ  one-hot grant, registered; all-zero when free
//   gnt_id     out  ID_W     binary index of owner; valid only when gnt_valid=1
//   gnt_valid  out  1        registered; equals |gnt
//   timeout    out  1        1-cycle pulse: previous grant was forcibly ended
// BEHAVIOUR
//   Reset (rst=1 at posedge): gnt=0, gnt_id=0, gnt_valid=0, timeout=0,
//     state=IDLE, hold_cnt=0, last_owner=NUM_REQ-1 (first RR search starts at 0).
//   States: IDLE (no owner), GRANT (one owner).
//   Arbitration point = any cycle in IDLE, or a release cycle in GRANT.
//     Candidates = req, with current owner masked off on a release cycle.
//     Fixed mode: highest-index candidate wins (bit NUM_REQ-1 top priority).
//     RR mode: first candidate searching last_owner+1, +2, ... with wrap mod NUM_REQ.
//     rr_mode sampled only at arbitration points; mid-grant changes ignored.
//   Latency: winner's gnt/gnt_id/gnt_valid appear the cycle after req is sampled.
//   IDLE: no candidate -> stay IDLE, outputs 0. Candidate -> GRANT, load
//     gnt/gnt_id, last_owner=winner, hold_cnt=0.
//   GRANT: hold_cnt increments each cycle. Release when any of:
//     done=1; req[owner]=0; MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (forced).
//     No release -> outputs unchanged.
//     Release with candidate -> next cycle gnt moves directly to new winner
//       (no idle gap), hold_cnt=0, last_owner updated.
//     Release without candidate -> next cycle gnt=0, gnt_valid=0, state IDLE;
//       a still-requesting old owner is re-granted from IDLE one cycle later.
//   timeout=1 for exactly the cycle after a forced release, and only if neither
//     done nor req[owner]=0 was also true (those take precedence: no pulse).
//   gnt always one-hot or zero; gnt_id never changes while gnt_valid stays 1
//     except at a release.
//   req bits for non-owners may change freely; only sampled at arbitration.
//   Reset mid-grant: next edge returns all state/outputs to reset values.
// TESTING
//   Reset: rst=1 two cycles, req=4'hF -> gnt=0, gnt_valid=0, timeout=0 throughout.
//   Fixed: rr_mode=0, req=4'b0110 -> next cycle gnt=4'b0100, gnt_id=2; pulse done
//     -> next cycle gnt=4'b0010, gnt_id=1 (no idle gap).
//   RR: rr_mode=1, req=4'hF held, done every grant cycle after reset -> gnt_id
//     sequence 0,1,2,3,0; same stimulus in fixed mode -> 3,2,3,2.
//   Timeout: MAX_HOLD=4, req=4'b0001 held, done=0 -> gnt=0001 for 4 cycles, then
//     gnt=0 with timeout=1 for one cycle, then gnt=0001 again.
//   Drop: owner id 2 lowers req[2] mid-grant, others 0 -> gnt=0 next cycle,
//     timeout=0, state IDLE.
//   Reset mid-grant: rst=1 while gnt=4'b1000 -> next cycle all outputs 0; after
//     release RR starts search at index 0.

Source files
------------

// File: rtl/req_arbiter.sv
// Grant arbiter that shares one resource among NUM_REQ requesters.
// Fixed (highest index) or round-robin selection, grant held until release, optional hold-time cap.
module req_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 16,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  input  logic               rr_mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, cand;
  logic [ID_W-1:0]    id_nxt, last_owner, last_nxt, winner;
  logic [HC_W-1:0]    hold_cnt, hold_nxt;
  logic               timeout_nxt, owner_req, forced, rel, arb;

  function automatic logic [ID_W-1:0] pick_fixed(input logic [NUM_REQ-1:0] c);
    logic [ID_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (c[i]) w = ID_W'(i);
    return w;
  endfunction

  // Search starts just after the previous owner and wraps around.
  function automatic logic [ID_W-1:0] pick_rr(input logic [NUM_REQ-1:0] c,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] w;
    logic [ID_W-1:0] iv;
    logic            found;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      iv = ID_W'((int'(last) + k) % NUM_REQ);
      if (!found && c[iv]) begin
        w     = iv;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    owner_req   = req[gnt_id];
    forced      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    rel         = (state == GRANT) && (done || !owner_req || forced);
    arb         = (state == IDLE) || rel;
    cand        = rel ? (req & ~gnt) : req;
    winner      = rr_mode ? pick_rr(cand, last_owner) : pick_fixed(cand);

    state_nxt   = state;
    gnt_nxt     = gnt;
    id_nxt      = gnt_id;
    last_nxt    = last_owner;
    hold_nxt    = hold_cnt + 1'b1;
    timeout_nxt = 1'b0;

    if (arb) begin
      hold_nxt    = '0;
      // A voluntary release or a dropped request outranks the hold limit.
      timeout_nxt = rel && forced && !done && owner_req;
      if (|cand) begin
        state_nxt = GRANT;
        gnt_nxt   = NUM_REQ'(1) << winner;
        id_nxt    = winner;
        last_nxt  = winner;
      end else begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        id_nxt    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= ID_W'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      gnt_id     <= id_nxt;
      gnt_valid  <= |gnt_nxt;
      timeout    <= timeout_nxt;
      hold_cnt   <= hold_nxt;
      last_owner <= last_nxt;
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: directed scenarios plus random traffic
// compared every cycle against an owner/hold-count reference model.
module tb_req_arbiter;

  localparam int N     = 4;
  localparam int MAXH  = 4;
  localparam int ID_W  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          done;
  logic          rr_mode;
  logic [N-1:0]  gnt;
  logic [ID_W-1:0] gnt_id;
  logic          gnt_valid;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_owner = -1;
  int m_hold  = 0;
  int m_last  = N - 1;
  bit m_tmo   = 1'b0;

  req_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .rr_mode(rr_mode),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int choose(input logic [N-1:0] r, input int excl, input bit rr, input int last);
    if (rr) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last + k) % N;
        if (r[i] && i != excl) return i;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit rel, forced, dropped;
    int win;
    if (rst) begin
      m_owner = -1; m_hold = 0; m_last = N - 1; m_tmo = 1'b0;
      return;
    end
    rel = 1'b0; forced = 1'b0; dropped = 1'b0;
    if (m_owner >= 0) begin
      forced  = (MAXH != 0) && (m_hold == MAXH - 1);
      dropped = !req[m_owner];
      rel     = done || dropped || forced;
    end
    if (m_owner >= 0 && !rel) begin
      m_hold++;
      m_tmo = 1'b0;
    end else begin
      win   = choose(req, m_owner, rr_mode, m_last);
      m_tmo = rel && forced && !done && !dropped;
      m_hold = 0;
      if (win >= 0) begin
        m_owner = win;
        m_last  = win;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("model_timeout", 32'(timeout), 32'(m_tmo));
    if (m_owner >= 0) chk("model_gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'hF; done = 1'b0; rr_mode = 1'b0;

    // reset held two cycles with all requests active
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_valid", 32'(gnt_valid), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    end
    rst = 1'b0;

    // fixed priority with direct hand-over on done
    req = 4'b0110; rr_mode = 1'b0; done = 1'b0;
    tick();
    chk("fix_gnt0", 32'(gnt), 32'b0100);
    chk("fix_id0", 32'(gnt_id), 32'd2);
    done = 1'b1;
    tick();
    chk("fix_gnt1", 32'(gnt), 32'b0010);
    chk("fix_id1", 32'(gnt_id), 32'd1);
    done = 1'b0; req = 4'b0000;
    tick();
    chk("fix_idle", 32'(gnt_valid), 32'h0);

    // round-robin rotation with done every grant cycle
    do_reset();
    rr_mode = 1'b1; req = 4'hF; done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq", 32'(gnt_id), 32'(i % 4));
    end

    // same stimulus in fixed mode ping-pongs between the top two
    do_reset();
    rr_mode = 1'b0; req = 4'hF; done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fix_seq", 32'(gnt_id), (i % 2 == 0) ? 32'd3 : 32'd2);
    end

    // hold-time limit with a single persistent requester
    do_reset();
    rr_mode = 1'b0; req = 4'b0001; done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tmo_hold_gnt", 32'(gnt), 32'b0001);
      chk("tmo_hold_pulse", 32'(timeout), 32'h0);
    end
    tick();
    chk("tmo_gap_gnt", 32'(gnt), 32'h0);
    chk("tmo_pulse", 32'(timeout), 32'h1);
    tick();
    chk("tmo_regrant", 32'(gnt), 32'b0001);
    chk("tmo_pulse_end", 32'(timeout), 32'h0);

    // timeout suppressed when done coincides with the forced release
    req = 4'b0001; done = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    done = 1'b1;
    tick();
    chk("tmo_done_pulse", 32'(timeout), 32'h0);
    done = 1'b0;

    // owner drops its request
    do_reset();
    req = 4'b0100;
    tick();
    chk("drop_id", 32'(gnt_id), 32'd2);
    req = 4'b0000;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h0);
    chk("drop_timeout", 32'(timeout), 32'h0);
    tick();
    chk("drop_stay_idle", 32'(gnt_valid), 32'h0);

    // reset during a grant restarts the round-robin pointer
    do_reset();
    rr_mode = 1'b1; req = 4'b1000;
    tick();
    chk("mid_gnt", 32'(gnt), 32'b1000);
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_valid", 32'(gnt_valid), 32'h0);
    rst = 1'b0; req = 4'hF;
    tick();
    chk("mid_rr_start", 32'(gnt_id), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
